// File: rtl/victim_cache_ctrl_pkg.sv
// Shared widths, operation/state encodings and a priority-encode helper for the
// victim cache controller. The optional statistics feature is VC_STATS_EN.
package cache_def;

  localparam int INDEX_VC     = 4;
  localparam int DEPTH_VC     = 2 ** INDEX_VC;
  localparam int INDEX_WAY_VC = 3;
  localparam int NUM_WAYS_VC  = 8;
  localparam int TAG_VC       = 8;

  typedef enum logic {
    VC_LOOKUP = 1'b0,
    VC_INSERT = 1'b1
  } vc_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } vc_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [INDEX_WAY_VC-1:0] lowest_set(input logic [NUM_WAYS_VC-1:0] vec);
    logic [INDEX_WAY_VC-1:0] r;
    r = 3'd0;
    for (int i = NUM_WAYS_VC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r = 3'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/victim_cache_ctrl_if.sv
// Request/response handshake bundle between the L1 miss path and the victim
// cache controller. Signal suffixes are from the controller's point of view.
interface victim_cache_ctrl_if;
  import cache_def::*;

  logic                    req_valid_i;
  logic                    req_ready_o;
  vc_op_e                  req_op_i;
  logic [INDEX_VC-1:0]     req_index_i;
  logic [TAG_VC-1:0]       req_tag_i;
  logic                    req_dirty_i;
  logic                    resp_valid_o;
  logic                    resp_ready_i;
  logic                    resp_hit_o;
  logic [INDEX_WAY_VC-1:0] resp_way_o;
  logic                    resp_evict_o;
  logic                    resp_evict_dirty_o;
  logic [TAG_VC-1:0]       resp_evict_tag_o;

  modport master (
    output req_valid_i, req_op_i, req_index_i, req_tag_i, req_dirty_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_hit_o, resp_way_o, resp_evict_o,
           resp_evict_dirty_o, resp_evict_tag_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_index_i, req_tag_i, req_dirty_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_hit_o, resp_way_o, resp_evict_o,
           resp_evict_dirty_o, resp_evict_tag_o
  );

endinterface

// File: rtl/victim_cache_pLRU.sv
// Per-set 8-way tree pseudo-LRU. Victim is read combinationally; an access
// pulse on valid_i steers every node on the accessed path away from that way.
module victim_cache_pLRU
  import cache_def::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [INDEX_VC-1:0]     index_i,
  input  logic                    valid_i,
  input  logic [INDEX_WAY_VC-1:0] address_i,
  output logic [INDEX_WAY_VC-1:0] victim_o
);

  // Node 0 is the root, nodes 1-2 split the halves, nodes 3-6 pick within pairs.
  logic [6:0] tree_q [DEPTH_VC];
  logic [6:0] tree_d;
  logic [6:0] cur_s;
  logic [2:0] mid_node_s;
  logic [2:0] leaf_node_s;
  logic [2:0] vic_leaf_s;

  // Walk the tree of the addressed set to find the victim way.
  always_comb begin
    cur_s       = tree_q[index_i];
    victim_o[2] = cur_s[0];
    victim_o[1] = cur_s[0] ? cur_s[2] : cur_s[1];
    vic_leaf_s  = 3'd3 + {1'b0, victim_o[2], victim_o[1]};
    victim_o[0] = cur_s[vic_leaf_s];
  end

  // Point the accessed path's nodes at the opposite subtree.
  always_comb begin
    tree_d              = cur_s;
    mid_node_s          = 3'd1 + {2'b00, address_i[2]};
    leaf_node_s         = 3'd3 + {1'b0, address_i[2:1]};
    tree_d[0]           = ~address_i[2];
    tree_d[mid_node_s]  = ~address_i[1];
    tree_d[leaf_node_s] = ~address_i[0];
  end

  // Tree state storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < DEPTH_VC; s++) begin
        tree_q[s] <= 7'd0;
      end
    end else if (valid_i) begin
      tree_q[index_i] <= tree_d;
    end
  end

endmodule

// File: rtl/victim_cache_ctrl.sv
// Victim cache sequencing controller: IDLE/CMP/RESP FSM owning tag/valid/dirty
// state; optional LOOKUP hit/miss counters when VC_STATS_EN is defined.
module victim_cache_ctrl
  import cache_def::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
`ifdef VC_STATS_EN
  output logic [15:0]        hit_cnt_o,
  output logic [15:0]        miss_cnt_o,
`endif
  victim_cache_ctrl_if.slave bus
);

  vc_state_e               state_q, state_d;
  vc_op_e                  op_q, op_d;
  logic [INDEX_VC-1:0]     index_q, index_d;
  logic [TAG_VC-1:0]       tag_q, tag_d;
  logic                    req_dirty_q, req_dirty_d;

  logic [TAG_VC-1:0]       tag_arr_q [DEPTH_VC][NUM_WAYS_VC];
  logic [NUM_WAYS_VC-1:0]  valid_arr_q [DEPTH_VC];
  logic [NUM_WAYS_VC-1:0]  dirty_arr_q [DEPTH_VC];

  logic [NUM_WAYS_VC-1:0]  set_valid_s, set_dirty_s, hit_vec_s;
  logic [NUM_WAYS_VC-1:0]  set_valid_d, set_dirty_d;
  logic                    hit_s, free_s;
  logic [INDEX_WAY_VC-1:0] hit_way_s, free_way_s, victim_s, alloc_way_s;
  logic                    arr_we_s, tag_we_s, plru_valid_s;

  logic                    req_ready_q, req_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_hit_q, resp_hit_d;
  logic [INDEX_WAY_VC-1:0] resp_way_q, resp_way_d;
  logic                    resp_evict_q, resp_evict_d;
  logic                    resp_evict_dirty_q, resp_evict_dirty_d;
  logic [TAG_VC-1:0]       resp_evict_tag_q, resp_evict_tag_d;

  victim_cache_pLRU u_plru (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .index_i   (index_q),
    .valid_i   (plru_valid_s),
    .address_i (alloc_way_s),
    .victim_o  (victim_s)
  );

  // Tag compare against every way of the registered set.
  always_comb begin
    set_valid_s = valid_arr_q[index_q];
    set_dirty_s = dirty_arr_q[index_q];
    hit_vec_s   = {NUM_WAYS_VC{1'b0}};
    for (int w = 0; w < NUM_WAYS_VC; w++) begin
      hit_vec_s[w] = set_valid_s[w] && (tag_arr_q[index_q][w] == tag_q);
    end
    hit_s      = |hit_vec_s;
    free_s     = ~&set_valid_s;
    hit_way_s  = lowest_set(hit_vec_s);
    free_way_s = lowest_set(~set_valid_s);
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.req_valid_i ? CMP : IDLE;
      CMP:     state_d = RESP;
      RESP:    state_d = bus.resp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request capture, array/pLRU write controls, response fields.
  always_comb begin
    op_d               = op_q;
    index_d            = index_q;
    tag_d              = tag_q;
    req_dirty_d        = req_dirty_q;
    set_valid_d        = set_valid_s;
    set_dirty_d        = set_dirty_s;
    arr_we_s           = 1'b0;
    tag_we_s           = 1'b0;
    plru_valid_s       = 1'b0;
    alloc_way_s        = 3'd0;
    resp_hit_d         = resp_hit_q;
    resp_way_d         = resp_way_q;
    resp_evict_d       = resp_evict_q;
    resp_evict_dirty_d = resp_evict_dirty_q;
    resp_evict_tag_d   = resp_evict_tag_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          op_d        = bus.req_op_i;
          index_d     = bus.req_index_i;
          tag_d       = bus.req_tag_i;
          req_dirty_d = bus.req_dirty_i;
        end else begin
          op_d        = op_q;
        end
      end
      CMP: begin
        resp_hit_d         = hit_s;
        resp_evict_d       = 1'b0;
        resp_evict_dirty_d = 1'b0;
        resp_evict_tag_d   = {TAG_VC{1'b0}};
        if (op_q == VC_LOOKUP) begin
          // A hit line returns to L1, so its way is freed here.
          resp_way_d = hit_s ? hit_way_s : 3'd0;
          if (hit_s) begin
            arr_we_s               = 1'b1;
            set_valid_d[hit_way_s] = 1'b0;
            set_dirty_d[hit_way_s] = 1'b0;
          end else begin
            arr_we_s = 1'b0;
          end
        end else begin
          if (hit_s) begin
            alloc_way_s = hit_way_s;
          end else if (free_s) begin
            alloc_way_s = free_way_s;
          end else begin
            alloc_way_s        = victim_s;
            resp_evict_d       = 1'b1;
            resp_evict_dirty_d = set_dirty_s[victim_s];
            resp_evict_tag_d   = tag_arr_q[index_q][victim_s];
          end
          arr_we_s                 = 1'b1;
          tag_we_s                 = 1'b1;
          plru_valid_s             = 1'b1;
          set_valid_d[alloc_way_s] = 1'b1;
          set_dirty_d[alloc_way_s] = req_dirty_q | (hit_s & set_dirty_s[alloc_way_s]);
          resp_way_d               = alloc_way_s;
        end
      end
      RESP: begin
        resp_hit_d = resp_hit_q;
      end
      default: begin
        resp_hit_d = resp_hit_q;
      end
    endcase
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  // Captured request and registered response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q               <= VC_LOOKUP;
      index_q            <= {INDEX_VC{1'b0}};
      tag_q              <= {TAG_VC{1'b0}};
      req_dirty_q        <= 1'b0;
      req_ready_q        <= 1'b1;
      resp_valid_q       <= 1'b0;
      resp_hit_q         <= 1'b0;
      resp_way_q         <= 3'd0;
      resp_evict_q       <= 1'b0;
      resp_evict_dirty_q <= 1'b0;
      resp_evict_tag_q   <= {TAG_VC{1'b0}};
    end else begin
      op_q               <= op_d;
      index_q            <= index_d;
      tag_q              <= tag_d;
      req_dirty_q        <= req_dirty_d;
      req_ready_q        <= req_ready_d;
      resp_valid_q       <= resp_valid_d;
      resp_hit_q         <= resp_hit_d;
      resp_way_q         <= resp_way_d;
      resp_evict_q       <= resp_evict_d;
      resp_evict_dirty_q <= resp_evict_dirty_d;
      resp_evict_tag_q   <= resp_evict_tag_d;
    end
  end

  // Tag/valid/dirty arrays; reset discards any write of the current cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < DEPTH_VC; s++) begin
        valid_arr_q[s] <= {NUM_WAYS_VC{1'b0}};
        dirty_arr_q[s] <= {NUM_WAYS_VC{1'b0}};
        for (int w = 0; w < NUM_WAYS_VC; w++) begin
          tag_arr_q[s][w] <= {TAG_VC{1'b0}};
        end
      end
    end else begin
      if (arr_we_s) begin
        valid_arr_q[index_q] <= set_valid_d;
        dirty_arr_q[index_q] <= set_dirty_d;
      end
      if (tag_we_s) begin
        tag_arr_q[index_q][alloc_way_s] <= tag_q;
      end
    end
  end

  assign bus.req_ready_o        = req_ready_q;
  assign bus.resp_valid_o       = resp_valid_q;
  assign bus.resp_hit_o         = resp_hit_q;
  assign bus.resp_way_o         = resp_way_q;
  assign bus.resp_evict_o       = resp_evict_q;
  assign bus.resp_evict_dirty_o = resp_evict_dirty_q;
  assign bus.resp_evict_tag_o   = resp_evict_tag_q;

`ifdef VC_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // Saturating LOOKUP outcome counters.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == CMP) && (op_q == VC_LOOKUP)) begin
      if (hit_s && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_d = hit_cnt_q + 16'd1;
      end else if (!hit_s && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_d = miss_cnt_q + 16'd1;
      end else begin
        hit_cnt_d = hit_cnt_q;
      end
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
  end

  // Counter storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
